fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end for the five-stage RV32IMF pipeline. It sits directly upstream of the Fetch→Decode pipeline register. It issues sequential requests to a variable-latency instruction memory over a req/gnt/rvalid interface and buffers returned words with their PCs in a small queue. It presents one instruction per cycle to decode, honours the hazard-unit stall, and handles branch/jump redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_prefetch_unit_if.sv | 13 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_prefetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and queue entry type for the fetch front end
package fetch_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - instruction memory req/gnt/rvalid bus
interface fetch_prefetch_unit_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of fetched words with flush; head is visible combinationally
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - sequential prefetcher with redirect flush/drain for the decode stage
// Optional FETCH_BYPASS_EN: an rvalid into an empty queue is shown to decode in the same cycle.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          pc_sel,
  input  logic [31:0]                   pc_nxt,
  fetch_prefetch_unit_if.master         imem,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pc_out,
  output logic                          instr_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, push_pc, last_pc;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty, q_push, q_pop;
  fetch_entry_t  q_head;
  logic          grant, resp_keep, bypass, req_ok;

  assign grant           = imem.req && imem.gnt;
  assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem.rvalid);
  // Queued words plus in-flight requests never exceed DEPTH, so pushes cannot overflow.
  assign req_ok          = ((CW+1)'(q_count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
  assign resp_keep       = imem.rvalid && (discard == '0) && !pc_sel;

`ifdef FETCH_BYPASS_EN
  assign bypass = q_empty && (discard == '0) && !pc_sel && imem.rvalid;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = resp_keep && !(bypass && !stall);
  assign q_pop  = !q_empty && !stall && !pc_sel;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (pc_sel),
    .push      (q_push),
    .push_data ('{pc: push_pc, instr: imem.rdata}),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // A redirect discards everything still in flight, including a same-cycle grant.
  always_comb begin
    discard_nxt = discard;
    if (pc_sel)                             discard_nxt = outstanding_nxt;
    else if (imem.rvalid && discard != '0)  discard_nxt = discard - 1'b1;
    state_nxt = state;
    case (state)
      FETCH:   if (discard_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (discard_nxt == '0) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem.req    = !rst && (state == FETCH) && !pc_sel && req_ok && !q_full;
    imem.addr   = fetch_pc;
    instruction = NOP_INSTR;
    pc_out      = last_pc;
    instr_valid = 1'b0;
    if (bypass) begin
      instruction = imem.rdata;
      pc_out      = push_pc;
      instr_valid = 1'b1;
    end else if (!q_empty) begin
      instruction = q_head.instr;
      pc_out      = q_head.pc;
      instr_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      push_pc     <= RESET_PC;
      last_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (pc_sel)      fetch_pc <= pc_nxt;
      else if (grant)  fetch_pc <= fetch_pc + 32'd4;
      if (pc_sel)         push_pc <= pc_nxt;
      else if (resp_keep) push_pc <= push_pc + 32'd4;
      if (bypass && !stall) last_pc <= push_pc;
      else if (q_pop)       last_pc <= q_head.pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed and randomized checks against an in-order memory and a PC-stream model
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_nxt;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  fetch_prefetch_unit_if imem_if();

  fetch_prefetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .pc_nxt      (pc_nxt),
    .imem        (imem_if),
    .instruction (instruction),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc;
  int          first_valid;
  int          consumed = 0;
  int          lat_max;
  logic [31:0] exp_pc, exp_req;
  logic [31:0] mq_addr [$];
  int          mq_rdy  [$];
  bit          hold_prev;
  logic [31:0] prev_pc, prev_instr;
  logic        last_req, last_valid;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; pc_sel = 1'b0; pc_nxt = '0;
    imem_if.gnt = 1'b0; imem_if.rvalid = 1'b0; imem_if.rdata = '0;
    mq_addr.delete(); mq_rdy.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", imem_if.req, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_instr", instruction, DEFAULT_NOP_INSTR);
    chk("reset_pc", pc_out, 0);
    rst = 1'b0;
    exp_pc = DEFAULT_RESET_PC; exp_req = DEFAULT_RESET_PC;
    hold_prev = 1'b0; cyc = 0; first_valid = -1;
  endtask

  task automatic step(input bit s, input bit sel, input logic [31:0] nxt, input bit g, input bit resp_en);
    bit granted;
    @(negedge clk);
    stall = s; pc_sel = sel; pc_nxt = nxt; imem_if.gnt = g;
    if (resp_en && mq_rdy.size() > 0 && mq_rdy[0] <= cyc) begin
      imem_if.rvalid = 1'b1; imem_if.rdata = memfn(mq_addr[0]);
    end else begin
      imem_if.rvalid = 1'b0; imem_if.rdata = $urandom;
    end
    #1;
    if (sel) chk("req_in_redirect", imem_if.req, 0);
    if (imem_if.req) chk("addr_align", {30'd0, imem_if.addr[1:0]}, 0);
    granted = imem_if.req && g;
    if (granted) chk("req_addr", imem_if.addr, exp_req);
    if (!instr_valid) chk("idle_nop", instruction, DEFAULT_NOP_INSTR);
    if (hold_prev) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", pc_out, prev_pc);
      chk("hold_instr", instruction, prev_instr);
    end
    if (instr_valid && !s && !sel) begin
      chk("pc_seq", pc_out, exp_pc);
      chk("instr_word", instruction, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    hold_prev = instr_valid && s && !sel;
    prev_pc = pc_out; prev_instr = instruction;
    last_req = imem_if.req; last_valid = instr_valid;
    if (sel) begin exp_pc = nxt; exp_req = nxt; end
    if (imem_if.rvalid) begin void'(mq_addr.pop_front()); void'(mq_rdy.pop_front()); end
    if (granted) begin
      mq_addr.push_back(exp_req);
      mq_rdy.push_back(cyc + 1 + int'($urandom_range(0, lat_max)));
      exp_req = exp_req + 32'd4;
    end
    @(posedge clk);
    if (mq_addr.size() > DEPTH) chk("outstanding_cap", mq_addr.size(), DEPTH);
    cyc++;
  endtask

  initial begin
    logic [31:0] tmp;
    lat_max = 0;
    do_reset();

    // Zero-wait memory: first valid output and a gap-free PC stream.
    repeat (10) step(0, 0, '0, 1, 1);
`ifdef FETCH_BYPASS_EN
    chk("first_valid_cycle", first_valid + 1, 2);
`else
    chk("first_valid_cycle", first_valid + 1, 3);
`endif

    // Held stall fills the queue and throttles requests.
    repeat (8) step(1, 0, '0, 1, 1);
    chk("stall_req_drop", last_req, 0);
    chk("stall_still_valid", last_valid, 1);
    repeat (10) step(0, 0, '0, 1, 1);

    // Three requests in flight, then redirect to 0x100.
    repeat (8) step(0, 0, '0, 0, 1);
    repeat (3) step(0, 0, '0, 1, 0);
    chk("three_inflight", mq_addr.size(), 3);
    step(0, 1, 32'h100, 0, 0);
    repeat (20) step(0, 0, '0, 1, 1);

    // Redirect coincident with stall and a response.
    repeat (8) step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 0);
    step(1, 1, 32'h200, 0, 1);
    step(0, 0, '0, 0, 0);
    chk("flush_empty", last_valid, 0);
    repeat (10) step(0, 0, '0, 1, 1);

    // Fetch address wraps past the top of memory.
    repeat (8) step(0, 0, '0, 0, 1);
    step(0, 1, 32'hFFFF_FFF8, 0, 1);
    repeat (12) step(0, 0, '0, 1, 1);

    // Randomized traffic with variable latency and a mid-run reset.
    lat_max = 3;
    for (int i = 0; i < 1400; i++) begin
      if (i == 700) do_reset();
      tmp = $urandom;
      if ($urandom_range(0, 7) == 0) tmp = 32'hFFFF_FFF0;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, {tmp[31:2], 2'b00},
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    chk("progress", consumed >= 150, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
